// File: rtl/softreg_seq_pkg.sv
// rtl/softreg_seq_pkg.sv - shared types and widths for the softreg config sequencer
package softreg_seq_pkg;

    localparam int unsigned SOFTREG_ADDR_W = 32;
    localparam int unsigned SOFTREG_DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_POLL_REQ  = 3'd2,
        S_POLL_WAIT = 3'd3,
        S_GAP       = 3'd4,
        S_DONE      = 3'd5
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/softreg_seq_timer.sv
// rtl/softreg_seq_timer.sv - loadable down-counter with expiry flag
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          load load_val_i (takes priority over counting)
//   load_val_i      number of counting cycles until expiry
//   count_i         decrement enable for this cycle
//   expire_o        high in the last counting cycle of a loaded interval
module softreg_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         count_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N expires in the Nth counting cycle after the load edge.
    assign expire_o = count_i && (cnt_q <= W'(1));

endmodule

// File: rtl/softreg_cfg_seq.sv
// rtl/softreg_cfg_seq.sv - issues a table of softreg config writes, then polls a status register
//
// Build option: define SOFTREG_SEQ_TIMEOUT_EN to enable the poll timeout.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start                         one-cycle run request (accepted in IDLE/DONE)
//   cfg_addr_flat, cfg_data_flat  write table, entry i at [32i+:32] / [64i+:64]
//   poll_addr                     status register read for completion
//   softreg_req_*                 registered request bus (one-cycle pulses)
//   softreg_resp_valid/_data      read response
//   busy, done, result, timeout   run status
module softreg_cfg_seq
    import softreg_seq_pkg::*;
#(
    parameter int unsigned NUM_WRITES     = 7,
    parameter int unsigned POLL_GAP       = 16,
    parameter int unsigned RETRY_ON_ZERO  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [((NUM_WRITES > 0) ? NUM_WRITES : 1)*SOFTREG_ADDR_W-1:0] cfg_addr_flat,
    input  logic [((NUM_WRITES > 0) ? NUM_WRITES : 1)*SOFTREG_DATA_W-1:0] cfg_data_flat,
    input  logic [SOFTREG_ADDR_W-1:0]                              poll_addr,
    output logic                                                   softreg_req_valid,
    output logic                                                   softreg_req_isWrite,
    output logic [SOFTREG_ADDR_W-1:0]                              softreg_req_addr,
    output logic [SOFTREG_DATA_W-1:0]                              softreg_req_data,
    input  logic                                                   softreg_resp_valid,
    input  logic [SOFTREG_DATA_W-1:0]                              softreg_resp_data,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [SOFTREG_DATA_W-1:0]                              result,
    output logic                                                   timeout
);

    localparam int unsigned NW_EFF   = (NUM_WRITES > 0) ? NUM_WRITES : 1;
    localparam int unsigned IDX_W    = $clog2(NW_EFF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW_EFF - 1);
    localparam int unsigned CNT_W    = $clog2(max_u(POLL_GAP, TIMEOUT_CYCLES) + 1);

`ifdef SOFTREG_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    seq_state_e                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d, wr_idx;
    logic                      req_valid_q, req_valid_d;
    logic                      req_write_q, req_write_d;
    logic [SOFTREG_ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [SOFTREG_DATA_W-1:0] req_data_q, req_data_d;
    logic                      done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic [SOFTREG_DATA_W-1:0] result_q, result_d;
    logic [SOFTREG_ADDR_W-1:0] wr_addr;
    logic [SOFTREG_DATA_W-1:0] wr_data;
    logic                      polling;
    logic                      gap_load, gap_expire;
    logic                      to_load, to_expire_raw, to_expire;

    // Request registers are loaded one edge ahead, so the entry presented next
    // is the one after the current index while writing, else entry 0.
    assign wr_idx  = (state_q == S_WRITE) ? (idx_q + 1'b1) : '0;
    assign wr_addr = cfg_addr_flat[wr_idx*SOFTREG_ADDR_W +: SOFTREG_ADDR_W];
    assign wr_data = cfg_data_flat[wr_idx*SOFTREG_DATA_W +: SOFTREG_DATA_W];

    assign polling = (state_q == S_POLL_REQ) || (state_q == S_POLL_WAIT) || (state_q == S_GAP);

    softreg_seq_timer #(.W(CNT_W)) u_gap_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (gap_load),
        .load_val_i (CNT_W'(POLL_GAP)),
        .count_i    (state_q == S_GAP),
        .expire_o   (gap_expire)
    );

    // Loaded only when the first poll of a run is issued; re-polls after a
    // gap keep counting from that point.
    softreg_seq_timer #(.W(CNT_W)) u_timeout_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (to_load),
        .load_val_i (CNT_W'(TIMEOUT_CYCLES)),
        .count_i    (polling),
        .expire_o   (to_expire_raw)
    );

    assign to_expire = TIMEOUT_EN && to_expire_raw;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_valid_d = 1'b0;
        req_write_d = 1'b0;
        req_addr_d  = '0;
        req_data_d  = '0;
        done_d      = done_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        gap_load    = 1'b0;
        to_load     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    result_d  = '0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    req_valid_d = 1'b1;
                    if (NUM_WRITES == 0) begin
                        state_d    = S_POLL_REQ;
                        req_addr_d = poll_addr;
                        to_load    = 1'b1;
                    end else begin
                        state_d     = S_WRITE;
                        req_write_d = 1'b1;
                        req_addr_d  = wr_addr;
                        req_data_d  = wr_data;
                    end
                end
            end

            S_WRITE: begin
                req_valid_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d    = S_POLL_REQ;
                    req_addr_d = poll_addr;
                    to_load    = 1'b1;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = wr_addr;
                    req_data_d  = wr_data;
                end
            end

            S_POLL_REQ: begin
                if (to_expire) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    result_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_POLL_WAIT;
                end
            end

            S_POLL_WAIT: begin
                // A response in the expiry cycle wins over the timeout.
                if (softreg_resp_valid) begin
                    if ((RETRY_ON_ZERO != 0) && (softreg_resp_data == '0)) begin
                        state_d  = S_GAP;
                        gap_load = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = softreg_resp_data;
                    end
                end else if (to_expire) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    result_d  = '0;
                    timeout_d = 1'b1;
                end
            end

            S_GAP: begin
                if (to_expire) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    result_d  = '0;
                    timeout_d = 1'b1;
                end else if (gap_expire) begin
                    state_d     = S_POLL_REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = poll_addr;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            done_q      <= done_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
        end
    end

    assign softreg_req_valid   = req_valid_q;
    assign softreg_req_isWrite = req_write_q;
    assign softreg_req_addr    = req_addr_q;
    assign softreg_req_data    = req_data_q;
    assign busy    = (state_q == S_WRITE) || polling;
    assign done    = done_q;
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_softreg_cfg_seq.sv
// tb/tb_softreg_cfg_seq.sv - self-checking bench for softreg_cfg_seq
module tb_softreg_cfg_seq;

    typedef struct packed {
        logic [31:0] cyc;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          idle_bad = 0;

    logic        start  [4];
    logic [31:0] poll   [4];
    logic        resp_v [4];
    logic [63:0] resp_d [4];
    logic        req_v  [4];
    logic        req_w  [4];
    logic [31:0] req_a  [4];
    logic [63:0] req_d  [4];
    logic        busy   [4];
    logic        done   [4];
    logic [63:0] res    [4];
    logic        tmo    [4];

    logic [7*32-1:0] a0;
    logic [7*64-1:0] d0;
    logic [2*32-1:0] a1;
    logic [2*64-1:0] d1;
    logic [31:0]     a2 = '0;
    logic [63:0]     d2 = '0;
    logic [31:0]     a3;
    logic [63:0]     d3;

    logic [31:0] exp_addr [8];
    logic [63:0] exp_data [8];
    req_t        exp_q [$];
    req_t        q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    softreg_cfg_seq #(.NUM_WRITES(7), .POLL_GAP(16), .RETRY_ON_ZERO(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .cfg_addr_flat(a0), .cfg_data_flat(d0),
        .poll_addr(poll[0]), .softreg_req_valid(req_v[0]), .softreg_req_isWrite(req_w[0]),
        .softreg_req_addr(req_a[0]), .softreg_req_data(req_d[0]),
        .softreg_resp_valid(resp_v[0]), .softreg_resp_data(resp_d[0]),
        .busy(busy[0]), .done(done[0]), .result(res[0]), .timeout(tmo[0]));

    softreg_cfg_seq #(.NUM_WRITES(2), .POLL_GAP(4), .RETRY_ON_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .cfg_addr_flat(a1), .cfg_data_flat(d1),
        .poll_addr(poll[1]), .softreg_req_valid(req_v[1]), .softreg_req_isWrite(req_w[1]),
        .softreg_req_addr(req_a[1]), .softreg_req_data(req_d[1]),
        .softreg_resp_valid(resp_v[1]), .softreg_resp_data(resp_d[1]),
        .busy(busy[1]), .done(done[1]), .result(res[1]), .timeout(tmo[1]));

    softreg_cfg_seq #(.NUM_WRITES(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .cfg_addr_flat(a2), .cfg_data_flat(d2),
        .poll_addr(poll[2]), .softreg_req_valid(req_v[2]), .softreg_req_isWrite(req_w[2]),
        .softreg_req_addr(req_a[2]), .softreg_req_data(req_d[2]),
        .softreg_resp_valid(resp_v[2]), .softreg_resp_data(resp_d[2]),
        .busy(busy[2]), .done(done[2]), .result(res[2]), .timeout(tmo[2]));

    softreg_cfg_seq #(.NUM_WRITES(1), .TIMEOUT_CYCLES(50)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .cfg_addr_flat(a3), .cfg_data_flat(d3),
        .poll_addr(poll[3]), .softreg_req_valid(req_v[3]), .softreg_req_isWrite(req_w[3]),
        .softreg_req_addr(req_a[3]), .softreg_req_data(req_d[3]),
        .softreg_resp_valid(resp_v[3]), .softreg_resp_data(resp_d[3]),
        .busy(busy[3]), .done(done[3]), .result(res[3]), .timeout(tmo[3]));

    // Bus monitor: log every request with its cycle; flag non-zero idle bus.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req_v[k]) begin
                q[k].push_back({32'(cyc), req_w[k], req_a[k], req_d[k]});
            end else if (req_w[k] || (req_a[k] != '0) || (req_d[k] != '0)) begin
                idle_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int c);
        at_cycle(c);
        @(negedge clk);
    endtask

    task automatic pulse_start(input int k, input int c);
        at_cycle(c);
        start[k] = 1'b1;
        at_cycle(c + 1);
        start[k] = 1'b0;
    endtask

    task automatic respond(input int k, input int c, input logic [63:0] data);
        at_cycle(c);
        resp_v[k] = 1'b1;
        resp_d[k] = data;
        at_cycle(c + 1);
        resp_v[k] = 1'b0;
        resp_d[k] = '0;
    endtask

    task automatic push_poll(input int c, input logic [31:0] pa);
        exp_q.push_back({32'(c), 1'b0, pa, 64'h0});
    endtask

    // Reference: write i lands start+1+i, first poll right after the last write.
    task automatic expect_seq(input int s, input int nw, input logic [31:0] pa);
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({32'(s + 1 + i), 1'b1, exp_addr[i], exp_data[i]});
        end
        push_poll(s + 1 + nw, pa);
    endtask

    task automatic cmp_reqs(input string tag, input int k);
        chk({tag, "_count"}, 64'(q[k].size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q[k].size(); i++) begin
            chk($sformatf("%s_cyc%0d", tag, i), 64'(q[k][i].cyc), 64'(exp_q[i].cyc));
            chk($sformatf("%s_wr%0d", tag, i), 64'(q[k][i].wr), 64'(exp_q[i].wr));
            chk($sformatf("%s_addr%0d", tag, i), 64'(q[k][i].addr), 64'(exp_q[i].addr));
            chk($sformatf("%s_data%0d", tag, i), q[k][i].data, exp_q[i].data);
        end
    endtask

    task automatic load_u0;
        for (int i = 0; i < 7; i++) begin
            a0[i*32 +: 32] = exp_addr[i];
            d0[i*64 +: 64] = exp_data[i];
        end
    endtask

    initial begin
        int s, p, lat, rc;
        logic [63:0] rd;

        for (int k = 0; k < 4; k++) begin
            start[k]  = 1'b0;
            resp_v[k] = 1'b0;
            resp_d[k] = '0;
            poll[k]   = 32'h40 + 32'(k);
        end
        exp_data[0] = 64'd10;   exp_data[1] = 64'd58;   exp_data[2] = 64'd0;
        exp_data[3] = 64'd80;   exp_data[4] = 64'd1240; exp_data[5] = 64'd1360;
        exp_data[6] = 64'd0;    exp_data[7] = 64'd0;
        for (int i = 0; i < 8; i++) exp_addr[i] = 32'(i * 8);
        load_u0();
        a1 = '0; d1 = '0; a3 = '0; d3 = '0;

        // Reset state
        sample(1);
        chk("rst_busy", 64'(busy[0]), 64'h0);
        chk("rst_done", 64'(done[0]), 64'h0);
        chk("rst_result", res[0], 64'h0);
        chk("rst_timeout", 64'(tmo[0]), 64'h0);
        chk("rst_req_valid", 64'(req_v[0]), 64'h0);
        at_cycle(2);
        rst = 1'b1;

        // Fixed table, start at cycle 3, response 20 cycles after the read
        q[0].delete();
        pulse_start(0, 3);
        pulse_start(0, 20);
        sample(30);
        chk("t1_busy_wait", 64'(busy[0]), 64'h1);
        chk("t1_done_wait", 64'(done[0]), 64'h0);
        respond(0, 31, 64'h2A);
        sample(32);
        chk("t1_done", 64'(done[0]), 64'h1);
        chk("t1_result", res[0], 64'h2A);
        chk("t1_busy", 64'(busy[0]), 64'h0);
        chk("t1_timeout", 64'(tmo[0]), 64'h0);
        expect_seq(3, 7, poll[0]);
        cmp_reqs("t1", 0);
        respond(0, 34, 64'h55);
        sample(37);
        chk("t1_hold_result", res[0], 64'h2A);
        chk("t1_hold_done", 64'(done[0]), 64'h1);

        // Randomized runs restarted from DONE
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 7; i++) begin
                exp_addr[i] = $urandom;
                exp_data[i] = {$urandom, $urandom};
            end
            poll[0] = $urandom;
            load_u0();
            q[0].delete();
            s = cyc + 2;
            pulse_start(0, s);
            sample(s + 1);
            chk($sformatf("r%0d_done_clr", it), 64'(done[0]), 64'h0);
            chk($sformatf("r%0d_result_clr", it), res[0], 64'h0);
            p   = s + 8;
            lat = $urandom_range(1, 30);
            rd  = {$urandom, $urandom};
            respond(0, p + lat, rd);
            sample(p + lat + 1);
            chk($sformatf("r%0d_done", it), 64'(done[0]), 64'h1);
            chk($sformatf("r%0d_result", it), res[0], rd);
            expect_seq(s, 7, poll[0]);
            cmp_reqs($sformatf("r%0d", it), 0);
        end

        // Reset while entry 3 is on the bus, with an ignored start mid-write
        q[0].delete();
        s = cyc + 2;
        pulse_start(0, s);
        pulse_start(0, s + 2);
        at_cycle(s + 4);
        rst = 1'b0;
        #1;
        chk("rst3_req_valid", 64'(req_v[0]), 64'h0);
        chk("rst3_req_addr", 64'(req_a[0]), 64'h0);
        chk("rst3_busy", 64'(busy[0]), 64'h0);
        chk("rst3_done", 64'(done[0]), 64'h0);
        chk("rst3_result", res[0], 64'h0);
        at_cycle(s + 5);
        rst = 1'b1;
        respond(0, s + 7, 64'h77);
        sample(s + 30);
        chk("rst3_done_after", 64'(done[0]), 64'h0);
        chk("rst3_busy_after", 64'(busy[0]), 64'h0);
        expect_seq(s, 7, poll[0]);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        cmp_reqs("rst3", 0);

        // Retry on zero: responses 0, 0, 7 with POLL_GAP = 4
        for (int i = 0; i < 2; i++) begin
            exp_addr[i] = $urandom;
            exp_data[i] = {$urandom, $urandom};
            a1[i*32 +: 32] = exp_addr[i];
            d1[i*64 +: 64] = exp_data[i];
        end
        q[1].delete();
        s = cyc + 2;
        pulse_start(1, s);
        expect_seq(s, 2, poll[1]);
        p  = s + 3;
        rc = p;
        for (int k = 0; k < 3; k++) begin
            lat = $urandom_range(1, 5);
            rc  = p + lat;
            respond(1, rc, (k < 2) ? 64'h0 : 64'h7);
            if (k < 2) begin
                sample(rc + 1);
                chk($sformatf("retry_gap_busy%0d", k), 64'(busy[1]), 64'h1);
                chk($sformatf("retry_gap_done%0d", k), 64'(done[1]), 64'h0);
                p = rc + 4 + 1;
                push_poll(p, poll[1]);
            end
        end
        sample(rc + 1);
        chk("retry_done", 64'(done[1]), 64'h1);
        chk("retry_result", res[1], 64'h7);
        chk("retry_busy", 64'(busy[1]), 64'h0);
        cmp_reqs("retry", 1);

        // NUM_WRITES = 0: poll straight after start
        q[2].delete();
        s = cyc + 2;
        pulse_start(2, s);
        respond(2, s + 3, 64'h1234);
        sample(s + 4);
        chk("nw0_done", 64'(done[2]), 64'h1);
        chk("nw0_result", res[2], 64'h1234);
        expect_seq(s, 0, poll[2]);
        cmp_reqs("nw0", 2);

        // Poll timeout
        exp_addr[0] = $urandom;
        exp_data[0] = {$urandom, $urandom};
        a3 = exp_addr[0];
        d3 = exp_data[0];
        s = cyc + 2;
        pulse_start(3, s);
        p = s + 2;
`ifdef SOFTREG_SEQ_TIMEOUT_EN
        sample(p + 49);
        chk("to_pre_timeout", 64'(tmo[3]), 64'h0);
        chk("to_pre_busy", 64'(busy[3]), 64'h1);
        sample(p + 50);
        chk("to_timeout", 64'(tmo[3]), 64'h1);
        chk("to_done", 64'(done[3]), 64'h1);
        chk("to_result", res[3], 64'h0);
        s = cyc + 2;
        pulse_start(3, s);
        p = s + 2;
        respond(3, p + 49, 64'h99);
        sample(p + 50);
        chk("to_edge_timeout", 64'(tmo[3]), 64'h0);
        chk("to_edge_done", 64'(done[3]), 64'h1);
        chk("to_edge_result", res[3], 64'h99);
`else
        sample(p + 60);
        chk("to_off_timeout", 64'(tmo[3]), 64'h0);
        chk("to_off_busy", 64'(busy[3]), 64'h1);
        respond(3, p + 61, 64'h99);
        sample(p + 62);
        chk("to_off_done", 64'(done[3]), 64'h1);
        chk("to_off_result", res[3], 64'h99);
        chk("to_off_timeout_end", 64'(tmo[3]), 64'h0);
`endif

        chk("idle_bus_zero", 64'(idle_bad), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softreg_cfg_seq.md
SOFTREG_CFG_SEQ -- requirements
Module: softreg_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_WRITES, default 7, number of config writes issued per run (0 allowed).
REQ-002 SHALL have parameter POLL_GAP, default 16, idle cycles between poll reads (min 1).
REQ-003 SHALL have parameter RETRY_ON_ZERO, default 0; 1 = zero read data means "not done, re-poll".
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, poll timeout (used only under REQ-030).
REQ-005 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle run request.
REQ-008 SHALL have port cfg_addr_flat  input  NUM_WRITES*32  write addresses, entry i at bits [32i+31:32i].
REQ-009 SHALL have port cfg_data_flat  input  NUM_WRITES*64  write data, entry i at bits [64i+63:64i].
REQ-010 SHALL have port poll_addr  input  32  softreg address read for completion.
REQ-011 SHALL have ports softreg_req_valid / softreg_req_isWrite (output 1), softreg_req_addr (output 32), softreg_req_data (output 64).
REQ-012 SHALL have ports softreg_resp_valid  input  1 and softreg_resp_data  input  64.
REQ-013 SHALL have outputs busy 1, done 1, result 64, timeout 1.

Function
REQ-014 SHALL implement states IDLE, WRITE, POLL_REQ, POLL_WAIT, GAP, DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, clear done/result/timeout, zero the write index and enter WRITE (or POLL_REQ if NUM_WRITES=0).
REQ-016 SHALL ignore start in WRITE, POLL_REQ, POLL_WAIT, GAP.
REQ-017 SHALL drive all softreg_req_* from registers; start sampled at edge t gives first write request in cycle t+1.
REQ-018 SHALL issue entry i in WRITE as a one-cycle pulse (valid=1, isWrite=1, addr/data = entry i), entries back-to-back in index order 0..NUM_WRITES-1, no ready/backpressure.
REQ-019 SHALL issue the poll read (valid=1, isWrite=0, addr=poll_addr, data=0) in the cycle after the last write, then enter POLL_WAIT.
REQ-020 SHALL hold softreg_req_valid=0 and addr/data/isWrite=0 in every cycle without a request.
REQ-021 SHALL, on softreg_resp_valid in POLL_WAIT, capture softreg_resp_data; if RETRY_ON_ZERO=1 and data=0 go to GAP, else set result and done=1 from the next cycle and enter DONE.
REQ-022 SHALL wait exactly POLL_GAP cycles in GAP, then re-enter POLL_REQ.
REQ-023 SHALL ignore softreg_resp_valid outside POLL_WAIT.
REQ-024 SHALL drive busy=1 in WRITE, POLL_REQ, POLL_WAIT, GAP; 0 otherwise.
REQ-025 SHALL hold done and result stable in DONE until the next accepted start or reset.

Reset
REQ-026 SHALL on rst=0 immediately force state IDLE, index/counters 0, all outputs 0, regardless of current state.
REQ-027 SHALL drop any outstanding poll on reset mid-run; a response arriving after reset release is ignored (REQ-023).

Configuration
REQ-028 SHALL support macro SOFTREG_SEQ_TIMEOUT_EN.
REQ-029 SHALL, without the macro, wait indefinitely in POLL_WAIT/GAP and tie timeout to 0.
REQ-030 SHALL, with the macro, count cycles from first poll issue; on reaching TIMEOUT_CYCLES enter DONE with timeout=1, done=1, result=0.
REQ-031 SHALL, with the macro, give a response arriving in the expiry cycle priority over timeout.

Structure
REQ-032 SHALL place the state enum and widths SOFTREG_ADDR_W=32, SOFTREG_DATA_W=64 in shared package softreg_seq_pkg.
REQ-033 SHALL implement gap and timeout counting in one sub-module softreg_seq_timer (load, count, expire).

Verification
REQ-034 SHALL test NUM_WRITES=7 table {N_VERT:10, N_INEDGES:58, VADDR:0, IEADDR:80, WRITE_ADDR0:1240, WRITE_ADDR1:1360, DONE_READ_PARAMS:0}, start at cycle 3 -> write pulses cycles 4..10 in order, read of DONE_ALL cycle 11.
REQ-035 SHALL test responder returning 0x2A 20 cycles after read, RETRY_ON_ZERO=0 -> result=0x2A, done=1 the cycle after, busy=0.
REQ-036 SHALL test RETRY_ON_ZERO=1, POLL_GAP=4, responses 0,0,7 -> three reads each 4 idle cycles after prior response, result=7.
REQ-037 SHALL test macro on, TIMEOUT_CYCLES=50, no response -> timeout=1, done=1, result=0 at poll+50; response in expiry cycle -> timeout=0.
REQ-038 SHALL test rst=0 during WRITE entry 3 and start during busy -> outputs 0 at once; ignored start issues no extra requests.
REQ-039 SHALL test NUM_WRITES=0 -> poll read in cycle after start, no write pulses.
